// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the program-counter generation stage.
package pc_gen_pkg;
  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;
endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between pc_gen (slave) and the pipeline around it (master).
interface pc_gen_if #(
  parameter int CNT_W = 32
);
  logic                          stall_i;
  logic                          redirect_valid_i;
  logic [pc_gen_pkg::XLEN-1:0]   redirect_pc_i;
  logic                          inv_addr_i;
  logic                          resume_i;
  logic [pc_gen_pkg::XLEN-1:0]   pc_o;
  logic [pc_gen_pkg::XLEN-1:0]   pc_plus4_o;
  logic                          fetch_valid_o;
  logic                          ifid_flush_o;
  logic                          halted_o;
  logic [pc_gen_pkg::XLEN-1:0]   epc_o;
  logic [CNT_W-1:0]              fetch_count_o;

  modport master (
    output stall_i, redirect_valid_i, redirect_pc_i, inv_addr_i, resume_i,
    input  pc_o, pc_plus4_o, fetch_valid_o, ifid_flush_o, halted_o, epc_o, fetch_count_o
  );

  modport slave (
    input  stall_i, redirect_valid_i, redirect_pc_i, inv_addr_i, resume_i,
    output pc_o, pc_plus4_o, fetch_valid_o, ifid_flush_o, halted_o, epc_o, fetch_count_o
  );
endinterface

// File: rtl/pc_gen_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end
endmodule

// File: rtl/pc_gen.sv
// Program-counter generation: boot delay, sequential fetch, redirects, fault halt.
// Optional macro PCGEN_TRAP_EN: first fault vectors to TRAP_VEC, double fault halts.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter logic [XLEN-1:0] TRAP_VEC   = 64'h0000_0000_0000_0100,
  parameter int              BOOT_DELAY = 2,
  parameter int              CNT_W      = 32
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
`ifdef PCGEN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int BW = (BOOT_DELAY < 1) ? 1 : $clog2(BOOT_DELAY + 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [BW-1:0]     boot_q;
  logic              fire, flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    fire    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      BOOT: begin
        if (boot_q == BW'(BOOT_DELAY - 1))
          state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_valid_i) begin
          // Redirect wins over everything, including a fault on the stale PC.
          pc_d  = bus.redirect_pc_i;
          flush = 1'b1;
        end else if (bus.inv_addr_i) begin
          epc_d = pc_q;
          flush = 1'b1;
          if (TRAP_EN && (pc_q != TRAP_VEC))
            pc_d = TRAP_VEC;
          else
            state_d = HALT;
        end else if (!bus.stall_i) begin
          fire = 1'b1;
          pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
      end
      HALT: begin
        if (bus.resume_i) begin
          state_d = RUN;
          flush   = 1'b1;
          pc_d    = bus.redirect_valid_i ? bus.redirect_pc_i : RESET_PC;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      boot_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      if (state_q == BOOT)
        boot_q <= boot_q + BW'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fire),
    .count (bus.fetch_count_o)
  );

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pc_q + XLEN'(INSTR_BYTES);
  assign bus.fetch_valid_o = fire;
  assign bus.ifid_flush_o  = flush;
  assign bus.halted_o      = (state_q == HALT);
  assign bus.epc_o         = epc_q;
endmodule
